// File: rtl/x86_m68k_bus_bridge.sv
// Host (x86 status bus) to 68k asynchronous bus cycle bridge.
// Claims windowed memory/IO cycles, steers byte lanes and splits 32-bit accesses into two word cycles.
module x86_m68k_bus_bridge #(
  parameter int unsigned       HOST_DW     = 16,
  parameter int unsigned       ADDR_W      = 24,
  parameter logic [ADDR_W-1:0] MEM_BASE    = ADDR_W'(24'h000000),
  parameter logic [ADDR_W-1:0] MEM_MASK    = ADDR_W'(24'hF00000),
  parameter logic [ADDR_W-1:0] IO_BASE     = ADDR_W'(24'h00E000),
  parameter int unsigned       SYNC_STAGES = 2,
  parameter int unsigned       TIMEOUT     = 255
) (
  input  logic                 P56,
  input  logic                 P54,
  input  logic                 host_s0_n,
  input  logic                 host_s1_n,
  input  logic                 host_mio,
  input  logic [ADDR_W-1:0]    host_addr,
  input  logic [HOST_DW/8-1:0] host_be_n,
  input  logic [HOST_DW-1:0]   host_wdata,
  output logic [HOST_DW-1:0]   host_rdata,
  output logic                 host_ready_n,
  output logic                 host_claim,
  output logic [ADDR_W-1:0]    m_addr,
  output logic                 m_as_n,
  output logic                 m_uds_n,
  output logic                 m_lds_n,
  output logic                 m_rw,
  output logic [15:0]          m_wdata,
  output logic                 m_oe,
  input  logic [15:0]          m_rdata,
  input  logic                 m_dtack_n,
  input  logic                 err_clr,
  output logic                 err_sticky
);

  localparam int unsigned BEW = HOST_DW / 8;
  localparam logic [ADDR_W-1:0] ALIGN = (HOST_DW == 32) ? ~ADDR_W'(3) : ~ADDR_W'(1);

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_DECODE = 3'd1;
  localparam logic [2:0] ST_ASSERT = 3'd2;
  localparam logic [2:0] ST_WAIT   = 3'd3;
  localparam logic [2:0] ST_NEGATE = 3'd4;
  localparam logic [2:0] ST_NEXT   = 3'd5;
  localparam logic [2:0] ST_READY  = 3'd6;

  logic [2:0]             state, state_d;
  logic [1:0]             st_prev;
  logic [SYNC_STAGES-1:0] dsync;
  logic [ADDR_W-1:0]      addr_r, addr_d;
  logic                   rw_r, rw_d;
  logic [3:0]             be_r, be_d;
  logic [31:0]            wd_r, wd_d;
  logic [31:0]            rbuf, rbuf_d;
  logic                   half_r, half_d;
  logic [7:0]             timer, timer_d;

  logic [ADDR_W-1:0]      m_addr_d;
  logic                   as_d, uds_d, lds_d, mrw_d, oe_d, rdy_d, claim_d, err_d;
  logic [15:0]            mwd_d;
  logic [HOST_DW-1:0]     hrd_d;

  logic [1:0]             st_cur;
  logic                   start, start_rd, claimed, dtack_s;
  logic [ADDR_W-1:0]      addr_aligned;
  logic                   l_half;
  logic [1:0]             l_be, cur_be;
  logic [15:0]            l_wd;
  logic                   launch, err_set;

  // Start is an idle-to-read/write status transition; IO cycles are always claimed
  assign st_cur       = {host_s1_n, host_s0_n};
  assign start        = (st_prev == 2'b11) && ((st_cur == 2'b01) || (st_cur == 2'b10));
  assign start_rd     = (st_cur == 2'b01);
  assign claimed      = host_mio ? ((host_addr & MEM_MASK) == MEM_BASE) : 1'b1;
  assign addr_aligned = (host_mio ? host_addr : (IO_BASE | ADDR_W'(host_addr[11:0]))) & ALIGN;
  assign dtack_s      = dsync[SYNC_STAGES-1];

  // Half about to be launched: from DECODE skip an empty low half, from NEXT always the high half
  assign l_half = (state == ST_DECODE) ? (be_r[1:0] == 2'b11) : 1'b1;
  assign l_be   = l_half ? be_r[3:2] : be_r[1:0];
  assign l_wd   = l_half ? wd_r[31:16] : wd_r[15:0];
  assign cur_be = half_r ? be_r[3:2] : be_r[1:0];

  always_comb begin
    state_d  = state;
    addr_d   = addr_r;
    rw_d     = rw_r;
    be_d     = be_r;
    wd_d     = wd_r;
    rbuf_d   = rbuf;
    half_d   = half_r;
    timer_d  = timer;
    m_addr_d = m_addr;
    as_d     = m_as_n;
    uds_d    = m_uds_n;
    lds_d    = m_lds_n;
    mrw_d    = m_rw;
    mwd_d    = m_wdata;
    oe_d     = m_oe;
    hrd_d    = host_rdata;
    rdy_d    = 1'b1;
    claim_d  = host_claim;
    err_d    = err_sticky;
    launch   = 1'b0;
    err_set  = 1'b0;

    if (err_clr) err_d = 1'b0;

    case (state)
      ST_IDLE: begin
        if (start && claimed) begin
          state_d             = ST_DECODE;
          addr_d              = addr_aligned;
          rw_d                = start_rd;
          be_d                = 4'hF;
          be_d[BEW-1:0]       = host_be_n;
          wd_d                = '0;
          wd_d[HOST_DW-1:0]   = host_wdata;
          rbuf_d              = '1;
          half_d              = 1'b0;
          claim_d             = 1'b1;
        end
      end
      ST_DECODE: begin
        if (be_r == 4'hF) begin
          err_set = 1'b1;
          state_d = ST_READY;
          rdy_d   = 1'b0;
          hrd_d   = rbuf[HOST_DW-1:0];
        end else begin
          launch = 1'b1;
        end
      end
      ST_ASSERT: begin
        state_d = ST_WAIT;
        timer_d = timer - 8'd1;
        if (!rw_r) begin
          uds_d = cur_be[0];
          lds_d = cur_be[1];
        end
      end
      ST_WAIT: begin
        if (!dtack_s) begin
          // Host little-endian lane 0 rides on the 68k upper byte
          if (rw_r) begin
            if (half_r) begin
              if (!cur_be[0]) rbuf_d[23:16] = m_rdata[15:8];
              if (!cur_be[1]) rbuf_d[31:24] = m_rdata[7:0];
            end else begin
              if (!cur_be[0]) rbuf_d[7:0]   = m_rdata[15:8];
              if (!cur_be[1]) rbuf_d[15:8]  = m_rdata[7:0];
            end
          end
          as_d    = 1'b1;
          uds_d   = 1'b1;
          lds_d   = 1'b1;
          oe_d    = 1'b0;
          state_d = ST_NEGATE;
        end else if (timer <= 8'd1) begin
          as_d    = 1'b1;
          uds_d   = 1'b1;
          lds_d   = 1'b1;
          oe_d    = 1'b0;
          timer_d = 8'd0;
          err_set = 1'b1;
          state_d = ST_READY;
          rdy_d   = 1'b0;
          hrd_d   = rbuf[HOST_DW-1:0];
        end else begin
          timer_d = timer - 8'd1;
        end
      end
      ST_NEGATE: begin
        if (dtack_s) state_d = ST_NEXT;
      end
      ST_NEXT: begin
        if (!half_r && (be_r[3:2] != 2'b11)) begin
          launch = 1'b1;
        end else begin
          state_d = ST_READY;
          rdy_d   = 1'b0;
          hrd_d   = rbuf[HOST_DW-1:0];
        end
      end
      ST_READY: begin
        state_d = ST_IDLE;
        claim_d = 1'b0;
      end
      default: state_d = ST_IDLE;
    endcase

    // Start one 68k word cycle; read strobes go with AS, write strobes wait a clock
    if (launch) begin
      state_d  = ST_ASSERT;
      half_d   = l_half;
      m_addr_d = l_half ? ADDR_W'(addr_r + ADDR_W'(2)) : addr_r;
      as_d     = 1'b0;
      mrw_d    = rw_r;
      mwd_d    = {l_wd[7:0], l_wd[15:8]};
      oe_d     = ~rw_r;
      timer_d  = 8'(TIMEOUT);
      if (rw_r) begin
        uds_d = l_be[0];
        lds_d = l_be[1];
      end
    end

    if (err_set) err_d = 1'b1;
  end

  always_ff @(posedge P56) begin
    if (P54) begin
      state        <= ST_IDLE;
      st_prev      <= 2'b11;
      dsync        <= '1;
      addr_r       <= '0;
      rw_r         <= 1'b1;
      be_r         <= 4'hF;
      wd_r         <= '0;
      rbuf         <= '0;
      half_r       <= 1'b0;
      timer        <= 8'd0;
      m_addr       <= '0;
      m_as_n       <= 1'b1;
      m_uds_n      <= 1'b1;
      m_lds_n      <= 1'b1;
      m_rw         <= 1'b1;
      m_wdata      <= '0;
      m_oe         <= 1'b0;
      host_rdata   <= '0;
      host_ready_n <= 1'b1;
      host_claim   <= 1'b0;
      err_sticky   <= 1'b0;
    end else begin
      state        <= state_d;
      st_prev      <= st_cur;
      dsync        <= {dsync[SYNC_STAGES-2:0], m_dtack_n};
      addr_r       <= addr_d;
      rw_r         <= rw_d;
      be_r         <= be_d;
      wd_r         <= wd_d;
      rbuf         <= rbuf_d;
      half_r       <= half_d;
      timer        <= timer_d;
      m_addr       <= m_addr_d;
      m_as_n       <= as_d;
      m_uds_n      <= uds_d;
      m_lds_n      <= lds_d;
      m_rw         <= mrw_d;
      m_wdata      <= mwd_d;
      m_oe         <= oe_d;
      host_rdata   <= hrd_d;
      host_ready_n <= rdy_d;
      host_claim   <= claim_d;
      err_sticky   <= err_d;
    end
  end

endmodule

// File: tb/tb_x86_m68k_bus_bridge.sv
// Directed bench for x86_m68k_bus_bridge: a 16-bit and a 32-bit host instance share clock and reset,
// one is selected per transaction while the other sees an idle bus.
module tb_x86_m68k_bus_bridge;

  logic        clk, rst, sel;
  logic        s1_n, s0_n, mio, dtack_n, err_clr;
  logic [23:0] haddr;
  logic [3:0]  be_n;
  logic [31:0] wdata;
  logic [15:0] mrdata;

  logic [15:0] rdata16, mwd16, mwd32;
  logic [31:0] rdata32;
  logic [23:0] maddr16, maddr32;
  logic rdy16, claim16, as16, uds16, lds16, rw16, oe16, err16;
  logic rdy32, claim32, as32, uds32, lds32, rw32, oe32, err32;

  logic [31:0] o_rdata;
  logic [23:0] o_maddr;
  logic [15:0] o_mwd;
  logic o_rdy, o_claim, o_as, o_uds, o_lds, o_rw, o_oe, o_err;

  int vec = 0;
  int miss = 0;

  int          n_as, n_rdy, as_len;
  int          ds_lag [2];
  logic [23:0] as_addr [2];
  logic [15:0] as_wd [2];
  logic        as_rw [2], as_oe [2], ds_u [2], ds_l [2];
  logic [31:0] rd_val;
  logic        claim_seen;

  x86_m68k_bus_bridge dut16 (
    .P56(clk), .P54(rst),
    .host_s0_n(sel | s0_n), .host_s1_n(sel | s1_n), .host_mio(mio),
    .host_addr(haddr), .host_be_n(be_n[1:0]), .host_wdata(wdata[15:0]),
    .host_rdata(rdata16), .host_ready_n(rdy16), .host_claim(claim16),
    .m_addr(maddr16), .m_as_n(as16), .m_uds_n(uds16), .m_lds_n(lds16), .m_rw(rw16),
    .m_wdata(mwd16), .m_oe(oe16), .m_rdata(mrdata), .m_dtack_n(sel | dtack_n),
    .err_clr(err_clr), .err_sticky(err16)
  );

  x86_m68k_bus_bridge #(.HOST_DW(32)) dut32 (
    .P56(clk), .P54(rst),
    .host_s0_n(~sel | s0_n), .host_s1_n(~sel | s1_n), .host_mio(mio),
    .host_addr(haddr), .host_be_n(be_n), .host_wdata(wdata),
    .host_rdata(rdata32), .host_ready_n(rdy32), .host_claim(claim32),
    .m_addr(maddr32), .m_as_n(as32), .m_uds_n(uds32), .m_lds_n(lds32), .m_rw(rw32),
    .m_wdata(mwd32), .m_oe(oe32), .m_rdata(mrdata), .m_dtack_n(~sel | dtack_n),
    .err_clr(err_clr), .err_sticky(err32)
  );

  assign o_rdata = sel ? rdata32 : {16'h0000, rdata16};
  assign o_maddr = sel ? maddr32 : maddr16;
  assign o_mwd   = sel ? mwd32 : mwd16;
  assign o_rdy   = sel ? rdy32 : rdy16;
  assign o_claim = sel ? claim32 : claim16;
  assign o_as    = sel ? as32 : as16;
  assign o_uds   = sel ? uds32 : uds16;
  assign o_lds   = sel ? lds32 : lds16;
  assign o_rw    = sel ? rw32 : rw16;
  assign o_oe    = sel ? oe32 : oe16;
  assign o_err   = sel ? err32 : err16;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // One host cycle plus a DTACK responder; records what the 68k side did
  task automatic run(input logic is32, input logic rd, input logic mem, input logic [23:0] a,
                     input logic [3:0] be, input logic [31:0] wd, input logic [15:0] rv,
                     input int dly, input logic ack, input int lim);
    int as_clk, post;
    logic prev_as, ds_seen;
    n_as = 0; n_rdy = 0; as_len = 0; rd_val = 'x; claim_seen = 1'b0;
    for (int i = 0; i < 2; i++) begin
      ds_lag[i] = -1; as_addr[i] = 'x; as_wd[i] = 'x; as_rw[i] = 1'bx; as_oe[i] = 1'bx;
      ds_u[i] = 1'bx; ds_l[i] = 1'bx;
    end
    sel = is32; mio = mem; haddr = a; be_n = be; wdata = wd; mrdata = rv;
    @(negedge clk);
    s1_n = ~rd; s0_n = rd;
    prev_as = 1'b1; as_clk = 0; post = 0; ds_seen = 1'b0;
    for (int c = 0; c < lim; c++) begin
      @(negedge clk);
      s1_n = 1'b1; s0_n = 1'b1;
      if (o_claim) claim_seen = 1'b1;
      if (!o_as) begin
        if (prev_as) begin
          if (n_as < 2) begin
            as_addr[n_as] = o_maddr; as_wd[n_as] = o_mwd; as_rw[n_as] = o_rw; as_oe[n_as] = o_oe;
          end
          n_as++; as_clk = 0; ds_seen = 1'b0;
        end else begin
          as_clk++;
        end
        if (!ds_seen && !(o_uds && o_lds)) begin
          ds_seen = 1'b1;
          if (n_as <= 2) begin
            ds_lag[n_as-1] = as_clk; ds_u[n_as-1] = o_uds; ds_l[n_as-1] = o_lds;
          end
        end
        if (ack && as_clk >= dly) dtack_n = 1'b0;
      end else begin
        if (!prev_as) as_len = as_clk + 1;
        dtack_n = 1'b1;
      end
      prev_as = o_as;
      if (!o_rdy) begin n_rdy++; rd_val = o_rdata; end
      if (n_rdy > 0) begin
        post++;
        if (post > 3) break;
      end
    end
    dtack_n = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    vec++; if ({as16, uds16, lds16, as32, uds32, lds32} !== 6'b111111) begin miss++; $display("FAIL reset_strobes got %b exp 111111", {as16, uds16, lds16, as32, uds32, lds32}); end
    vec++; if ({rw16, oe16, rw32, oe32} !== 4'b1010) begin miss++; $display("FAIL reset_rw_oe got %b exp 1010", {rw16, oe16, rw32, oe32}); end
    vec++; if ({maddr16, maddr32} !== 48'h0) begin miss++; $display("FAIL reset_maddr got %h exp 0", {maddr16, maddr32}); end
    vec++; if ({rdy16, claim16, rdy32, claim32} !== 4'b1010) begin miss++; $display("FAIL reset_ready_claim got %b exp 1010", {rdy16, claim16, rdy32, claim32}); end
    vec++; if ({rdata16, rdata32} !== 48'h0) begin miss++; $display("FAIL reset_rdata got %h exp 0", {rdata16, rdata32}); end
    vec++; if ({err16, err32} !== 2'b00) begin miss++; $display("FAIL reset_err got %b exp 00", {err16, err32}); end
  endtask

  task automatic test_read16();
    run(1'b0, 1'b1, 1'b1, 24'h000100, 4'b1100, 32'h0, 16'h1234, 3, 1'b1, 100);
    vec++; if (n_as !== 1) begin miss++; $display("FAIL rd16_as_count got %0d exp 1", n_as); end
    vec++; if (as_addr[0] !== 24'h000100) begin miss++; $display("FAIL rd16_addr got %h exp 000100", as_addr[0]); end
    vec++; if (as_rw[0] !== 1'b1) begin miss++; $display("FAIL rd16_rw got %b exp 1", as_rw[0]); end
    vec++; if ({ds_lag[0], ds_u[0], ds_l[0]} !== {32'sd0, 2'b00}) begin miss++; $display("FAIL rd16_ds got lag %0d u%b l%b exp lag 0 u0 l0", ds_lag[0], ds_u[0], ds_l[0]); end
    vec++; if (rd_val[15:0] !== 16'h3412) begin miss++; $display("FAIL rd16_data got %h exp 3412", rd_val[15:0]); end
    vec++; if (n_rdy !== 1) begin miss++; $display("FAIL rd16_ready_pulses got %0d exp 1", n_rdy); end
    vec++; if (claim_seen !== 1'b1) begin miss++; $display("FAIL rd16_claim got %b exp 1", claim_seen); end
    vec++; if (o_err !== 1'b0) begin miss++; $display("FAIL rd16_err got %b exp 0", o_err); end
  endtask

  task automatic test_byte_lanes16();
    run(1'b0, 1'b0, 1'b1, 24'h000101, 4'b1101, 32'h0000AB00, 16'h0, 2, 1'b1, 100);
    vec++; if (as_addr[0] !== 24'h000100) begin miss++; $display("FAIL wr_odd_addr got %h exp 000100", as_addr[0]); end
    vec++; if ({ds_u[0], ds_l[0]} !== 2'b10) begin miss++; $display("FAIL wr_odd_lanes got u%b l%b exp u1 l0", ds_u[0], ds_l[0]); end
    vec++; if (ds_lag[0] !== 1) begin miss++; $display("FAIL wr_odd_ds_lag got %0d exp 1", ds_lag[0]); end
    vec++; if (as_wd[0][7:0] !== 8'hAB) begin miss++; $display("FAIL wr_odd_data got %h exp AB", as_wd[0][7:0]); end
    vec++; if ({as_rw[0], as_oe[0]} !== 2'b01) begin miss++; $display("FAIL wr_odd_rw_oe got %b exp 01", {as_rw[0], as_oe[0]}); end
    vec++; if (n_rdy !== 1) begin miss++; $display("FAIL wr_odd_ready got %0d exp 1", n_rdy); end
    run(1'b0, 1'b1, 1'b1, 24'h000100, 4'b1110, 32'h0, 16'h5A00, 1, 1'b1, 100);
    vec++; if ({ds_u[0], ds_l[0]} !== 2'b01) begin miss++; $display("FAIL rd_even_lanes got u%b l%b exp u0 l1", ds_u[0], ds_l[0]); end
    vec++; if (rd_val[7:0] !== 8'h5A) begin miss++; $display("FAIL rd_even_data got %h exp 5A", rd_val[7:0]); end
  endtask

  task automatic test_split32();
    run(1'b1, 1'b0, 1'b1, 24'h000200, 4'b0000, 32'h11223344, 16'h0, 1, 1'b1, 200);
    vec++; if (n_as !== 2) begin miss++; $display("FAIL wr32_as_count got %0d exp 2", n_as); end
    vec++; if ({as_addr[0], as_wd[0]} !== {24'h000200, 16'h4433}) begin miss++; $display("FAIL wr32_low got %h/%h exp 000200/4433", as_addr[0], as_wd[0]); end
    vec++; if ({as_addr[1], as_wd[1]} !== {24'h000202, 16'h2211}) begin miss++; $display("FAIL wr32_high got %h/%h exp 000202/2211", as_addr[1], as_wd[1]); end
    vec++; if (n_rdy !== 1) begin miss++; $display("FAIL wr32_ready got %0d exp 1", n_rdy); end
    run(1'b1, 1'b0, 1'b1, 24'h000200, 4'b1100, 32'h11223344, 16'h0, 1, 1'b1, 200);
    vec++; if (n_as !== 1) begin miss++; $display("FAIL wr32_lo_as_count got %0d exp 1", n_as); end
    vec++; if ({as_addr[0], as_wd[0]} !== {24'h000200, 16'h4433}) begin miss++; $display("FAIL wr32_lo_only got %h/%h exp 000200/4433", as_addr[0], as_wd[0]); end
    run(1'b1, 1'b1, 1'b1, 24'h000204, 4'b0000, 32'h0, 16'h1234, 1, 1'b1, 200);
    vec++; if (as_addr[1] !== 24'h000206) begin miss++; $display("FAIL rd32_high_addr got %h exp 000206", as_addr[1]); end
    vec++; if (rd_val !== 32'h34123412) begin miss++; $display("FAIL rd32_data got %h exp 34123412", rd_val); end
  endtask

  task automatic test_io_and_window();
    run(1'b0, 1'b1, 1'b0, 24'h0003F8, 4'b1100, 32'h0, 16'hBEEF, 1, 1'b1, 100);
    vec++; if (as_addr[0] !== 24'h00E3F8) begin miss++; $display("FAIL io_addr got %h exp 00E3F8", as_addr[0]); end
    vec++; if (as_rw[0] !== 1'b1) begin miss++; $display("FAIL io_rw got %b exp 1", as_rw[0]); end
    run(1'b0, 1'b1, 1'b1, 24'h900000, 4'b1100, 32'h0, 16'h0, 1, 1'b1, 20);
    vec++; if ({n_as, n_rdy} !== {32'sd0, 32'sd0}) begin miss++; $display("FAIL unclaimed got as %0d ready %0d exp 0 0", n_as, n_rdy); end
    vec++; if (claim_seen !== 1'b0) begin miss++; $display("FAIL unclaimed_claim got %b exp 0", claim_seen); end
  endtask

  task automatic test_illegal_be();
    run(1'b0, 1'b1, 1'b1, 24'h000100, 4'b1111, 32'h0, 16'h0, 1, 1'b1, 50);
    vec++; if (n_as !== 0) begin miss++; $display("FAIL illegal_as got %0d exp 0", n_as); end
    vec++; if ({n_rdy, rd_val[15:0]} !== {32'sd1, 16'hFFFF}) begin miss++; $display("FAIL illegal_ready got %0d/%h exp 1/FFFF", n_rdy, rd_val[15:0]); end
    vec++; if (o_err !== 1'b1) begin miss++; $display("FAIL illegal_err got %b exp 1", o_err); end
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    vec++; if (o_err !== 1'b0) begin miss++; $display("FAIL illegal_err_clr got %b exp 0", o_err); end
  endtask

  task automatic test_timeout();
    run(1'b0, 1'b1, 1'b1, 24'h000300, 4'b1100, 32'h0, 16'h1234, 0, 1'b0, 600);
    vec++; if (as_len !== 255) begin miss++; $display("FAIL timeout_as_len got %0d exp 255", as_len); end
    vec++; if ({n_rdy, rd_val[15:0]} !== {32'sd1, 16'hFFFF}) begin miss++; $display("FAIL timeout_ready got %0d/%h exp 1/FFFF", n_rdy, rd_val[15:0]); end
    vec++; if (o_err !== 1'b1) begin miss++; $display("FAIL timeout_err got %b exp 1", o_err); end
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    vec++; if (o_err !== 1'b0) begin miss++; $display("FAIL timeout_err_clr got %b exp 0", o_err); end
  endtask

  task automatic test_reset_mid_cycle();
    int lows;
    sel = 1'b0; mio = 1'b1; haddr = 24'h000400; be_n = 4'b1100;
    @(negedge clk);
    s1_n = 1'b0; s0_n = 1'b1;
    @(negedge clk);
    s1_n = 1'b1; s0_n = 1'b1;
    for (int c = 0; c < 10; c++) begin
      if (!o_as) break;
      @(negedge clk);
    end
    repeat (4) @(negedge clk);
    vec++; if (o_as !== 1'b0) begin miss++; $display("FAIL rstmid_in_wait got as %b exp 0", o_as); end
    rst = 1'b1;
    @(negedge clk);
    vec++; if ({o_as, o_uds, o_lds, o_claim, o_rdy} !== 5'b11101) begin miss++; $display("FAIL rstmid_negate got %b exp 11101", {o_as, o_uds, o_lds, o_claim, o_rdy}); end
    rst = 1'b0;
    lows = 0;
    repeat (6) begin
      @(negedge clk);
      if (!o_rdy || !o_as) lows++;
    end
    vec++; if (lows !== 0) begin miss++; $display("FAIL rstmid_quiet got %0d active clocks exp 0", lows); end
    run(1'b0, 1'b1, 1'b1, 24'h000400, 4'b1100, 32'h0, 16'hCAFE, 1, 1'b1, 100);
    vec++; if ({n_rdy, rd_val[15:0]} !== {32'sd1, 16'hFECA}) begin miss++; $display("FAIL rstmid_recover got %0d/%h exp 1/FECA", n_rdy, rd_val[15:0]); end
  endtask

  initial begin
    rst = 1'b1; sel = 1'b0; s1_n = 1'b1; s0_n = 1'b1; mio = 1'b1; haddr = '0;
    be_n = 4'hF; wdata = '0; mrdata = '0; dtack_n = 1'b1; err_clr = 1'b0;
    test_reset();
    test_read16();
    test_byte_lanes16();
    test_split32();
    test_io_and_window();
    test_illegal_be();
    test_timeout();
    test_reset_mid_cycle();
    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end

endmodule

// File: doc/x86_m68k_bus_bridge.md
Name: x86_m68k_bus_bridge

Overview:
- Parametrised successor to the 286-to-Zorro cycle translator.
- Claims host (x86-style status bus) memory/IO cycles that fall in a programmable window and runs them as 68k asynchronous bus cycles (AS/UDS/LDS/RW/DTACK), with byte-lane steering and endian swap.
- New over the previous generation: HOST_DW=16 or 32 with automatic split into two 68k word cycles, synchronised DTACK, bus-timeout abort with sticky error, and a separate IO window.
- Sits between the host CPU bus and the Zorro/68k master interface.

Parameters:
HOST_DW, 16, host data width; 16 or 32 only.
ADDR_W, 24, 68k/host address width.
MEM_BASE, 24'h000000, memory window base (host M/IO=1).
MEM_MASK, 24'hF00000, set bits of the address compared against MEM_BASE.
IO_BASE, 24'h00E000, 68k address for host IO cycles; host IO address bits [11:0] are ORed in.
SYNC_STAGES, 2, DTACK synchroniser depth (>=2).
TIMEOUT, 255, clocks from AS assertion to abort; 8-bit counter.

Ports:
P56  in  1  clock (host clock)
P54  in  1  reset, synchronous, active-high
host_s0_n  in  1  host status S0, active low
host_s1_n  in  1  host status S1, active low
host_mio  in  1  1=memory cycle, 0=IO cycle
host_addr  in  ADDR_W  host address; bit0=A0 (16b) / bits[1:0] ignored (32b)
host_be_n  in  HOST_DW/8  byte enables, active low (16b: {BHE_n, A0})
host_wdata  in  HOST_DW  write data
host_rdata  out  HOST_DW  read data, valid while host_ready_n=0
host_ready_n  out  1  cycle complete, low for exactly one clock
host_claim  out  1  high from decode until ready for claimed cycles
m_addr  out  ADDR_W  68k address, bit0 always 0
m_as_n  out  1  address strobe
m_uds_n  out  1  upper data strobe
m_lds_n  out  1  lower data strobe
m_rw  out  1  1=read
m_wdata  out  16  68k write data
m_oe  out  1  m_wdata drive enable
m_rdata  in  16  68k read data
m_dtack_n  in  1  asynchronous DTACK
err_clr  in  1  clears err_sticky
err_sticky  out  1  set on timeout or illegal byte enables

Behaviour:
- Reset (P54=1 at edge): state IDLE; m_as_n=m_uds_n=m_lds_n=1, m_rw=1, m_oe=0, m_addr=0, host_ready_n=1, host_claim=0, host_rdata=0, err_sticky=0, timeout counter=0. Reset mid-cycle negates all strobes on that same edge; no host ready is issued.
- Start: status sampled every clock; read = S1_n=0,S0_n=1; write = S1_n=1,S0_n=0; other codes are not claimed. A start is a transition from 11 to read/write. The cycle is claimed if host_mio=1 and (host_addr&MEM_MASK)==MEM_BASE, or host_mio=0 (IO). Unclaimed cycles: outputs untouched.
- FSM: IDLE -> DECODE (1 clk: latch addr/data/BEs, build lane plan, host_claim=1) -> ASSERT (m_as_n=0; for reads UDS/LDS go low in the same clock; load timer) -> WAIT (for writes, DS goes low on the first WAIT clock, m_oe=1 from ASSERT) -> on synced DTACK=0: latch m_rdata, go to NEGATE (all strobes high, m_oe=0) -> wait for synced DTACK=1 -> NEXT (second half pending? go to ASSERT with m_addr+2 : READY) -> READY (host_ready_n=0 for one clock) -> IDLE.
- 16-bit lanes (68k big-endian):
  - BE_n=00: UDS+LDS, m_wdata={w[7:0],w[15:8]}, rdata swapped back.
  - BE_n=10 (A0=0, BHE_n=1): UDS only, w[7:0] on m[15:8].
  - BE_n=01: LDS only, w[15:8] on m[7:0].
  - BE_n=11: no 68k cycle; READY after DECODE, rdata=all ones, err_sticky=1.
- 32-bit: low word at addr[ADDR_W-1:2]<<2 using be_n[1:0], then high word at +2 using be_n[3:2]. A half whose BEs are 11 is skipped. All four BEs high = illegal, as above.
- IO cycles: m_addr = IO_BASE | host_addr[11:0] with bit0 cleared.
- Timeout: the timer decrements each clock in WAIT. At 0 with no synced DTACK: strobes negate, remaining halves are dropped, rdata lanes not yet filled = 0xFF, err_sticky=1, then READY (no DTACK-high wait).
- err_clr and a simultaneous error: set wins.
- A new status start while busy is ignored; the host must wait for ready.
- Minimum read latency with DTACK already low: DECODE + ASSERT + SYNC_STAGES + NEGATE + DTACK-high wait + READY.

Test Plan:
- Read word, HOST_DW=16: addr 0x000100, BE_n=00, m_rdata=0x1234, DTACK low 3 clks after AS -> UDS/LDS low together; host_rdata=0x3412; single ready pulse; err_sticky=0.
- Byte write odd: addr 0x000101, BE_n=01, wdata=0xAB00 -> m_addr=0x000100, LDS only, m_wdata[7:0]=0xAB; DS asserts 1 clk after AS.
- 32-bit write, BE_n=0000, addr 0x000200, wdata=0x11223344 -> two cycles at 0x200 (0x4433) and 0x202 (0x2211); one ready. With BE_n=1100 -> only the 0x200 cycle.
- Timeout: DTACK never asserted, TIMEOUT=255 -> strobes negate 255 clks after AS; rdata=0xFFFF; err_sticky=1; err_clr clears it next clock.
- IO read at host_addr 0x03F8 -> m_addr=0x00E3F8, RW=1; address 0x900000 with host_mio=1 is not claimed (no AS).
- Reset asserted during WAIT -> all strobes high on the next edge, no ready pulse, FSM in IDLE.
